// File: rtl/filter_output_decimator.sv
// Keeps every DECIM-th filter sample in a DEPTH-word FWFT buffer; one-cycle keep-to-output latency.
// Never back-pressures the filter: kept samples arriving with the buffer full are dropped and flagged in Overflow_o.
module filter_output_decimator #(
  parameter int DATA_W = 18,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8,
  parameter int LVL_W  = 4
) (
  input  logic              Clk_i,
  input  logic              RstN_i,
  input  logic [DATA_W-1:0] Data_i,
  input  logic              DataNd_i,
  input  logic              Ready_i,
  input  logic              ClearOvf_i,
  output logic [DATA_W-1:0] Data_o,
  output logic              DataValid_o,
  output logic              Overflow_o,
  output logic [LVL_W-1:0]  Level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_nxt;
  logic [PH_W-1:0]   phase;
  logic [LVL_W-1:0]  level, level_nxt;
  logic [DATA_W-1:0] data_q, head_nxt;
  logic              valid_q, ovf_q;
  logic              keep, xfer, full, wr_en, drop;

  assign keep  = DataNd_i && (phase == '0);
  assign xfer  = valid_q && Ready_i;
  assign full  = (level == LVL_W'(DEPTH));
  // A read on the same edge frees the slot a full-buffer write needs.
  assign wr_en = keep && (!full || xfer);
  assign drop  = keep && !wr_en;

  always_comb begin
    rd_nxt    = xfer ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt = level;
    case ({wr_en, xfer})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
    // The incoming word becomes the head only when it lands in the slot being presented next.
    if (wr_en && (wr_ptr == rd_nxt))
      head_nxt = Data_i;
    else
      head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge Clk_i) begin
    if (wr_en)
      mem[wr_ptr] <= Data_i;
  end

  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      phase   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (DataNd_i)
        phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_nxt;
      level   <= level_nxt;
      valid_q <= (level_nxt != '0);
      if (level_nxt != '0)
        data_q <= head_nxt;
      if (drop)
        ovf_q <= 1'b1;
      else if (ClearOvf_i)
        ovf_q <= 1'b0;
    end
  end

  assign Data_o      = data_q;
  assign DataValid_o = valid_q;
  assign Overflow_o  = ovf_q;
  assign Level_o     = level;

endmodule

// File: tb/tb_filter_output_decimator.sv
// Directed bench: three decimator instances (DECIM=4, 1, 3) share one stimulus stream.
module tb_filter_output_decimator;

  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          nd = 1'b0;
  logic          rdy = 1'b0;
  logic          clr = 1'b0;

  logic [DW-1:0] d4_dat, d1_dat, d3_dat;
  logic          d4_vld, d1_vld, d3_vld;
  logic          d4_ovf, d1_ovf, d3_ovf;
  logic [3:0]    d4_lvl, d1_lvl, d3_lvl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_output_decimator #(.DATA_W(DW), .DECIM(4), .DEPTH(8), .LVL_W(4)) u_d4 (
    .Clk_i(clk), .RstN_i(rst_n), .Data_i(din), .DataNd_i(nd), .Ready_i(rdy), .ClearOvf_i(clr),
    .Data_o(d4_dat), .DataValid_o(d4_vld), .Overflow_o(d4_ovf), .Level_o(d4_lvl));

  filter_output_decimator #(.DATA_W(DW), .DECIM(1), .DEPTH(8), .LVL_W(4)) u_d1 (
    .Clk_i(clk), .RstN_i(rst_n), .Data_i(din), .DataNd_i(nd), .Ready_i(rdy), .ClearOvf_i(clr),
    .Data_o(d1_dat), .DataValid_o(d1_vld), .Overflow_o(d1_ovf), .Level_o(d1_lvl));

  filter_output_decimator #(.DATA_W(DW), .DECIM(3), .DEPTH(8), .LVL_W(4)) u_d3 (
    .Clk_i(clk), .RstN_i(rst_n), .Data_i(din), .DataNd_i(nd), .Ready_i(rdy), .ClearOvf_i(clr),
    .Data_o(d3_dat), .DataValid_o(d3_vld), .Overflow_o(d3_ovf), .Level_o(d3_lvl));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 ns after it, where outputs are sampled and inputs changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nd    = 1'b0;
    rdy   = 1'b0;
    clr   = 1'b0;
    din   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_d4_dat", 32'(d4_dat), 0);
    chk("rst_d4_vld", 32'(d4_vld), 0);
    chk("rst_d4_ovf", 32'(d4_ovf), 0);
    chk("rst_d4_lvl", 32'(d4_lvl), 0);
    chk("rst_d1_vld", 32'(d1_vld), 0);
    chk("rst_d3_lvl", 32'(d3_lvl), 0);

    // Continuous stream: DECIM=4 keeps 1,5,9,13; DECIM=1 passes through with one-cycle delay
    rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      din = DW'(i);
      nd  = 1'b1;
      step();
      chk("str_d4_vld", 32'(d4_vld), 32'((i % 4) == 1));
      chk("str_d4_dat", 32'(d4_dat), 32'(i - ((i - 1) % 4)));
      chk("str_d4_lvl", 32'(d4_lvl), 32'((i % 4) == 1));
      chk("str_d1_dat", 32'(d1_dat), 32'(i));
      chk("str_d1_vld", 32'(d1_vld), 1);
      chk("str_d1_lvl", 32'(d1_lvl), 1);
    end
    nd = 1'b0;
    step();
    chk("str_d1_idle_vld", 32'(d1_vld), 0);

    // Back-pressure: fill 8, drop 9th and 10th, then drain in order
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      din = DW'(32'h100 + k - 1);
      nd  = 1'b1;
      step();
      chk("bp_lvl", 32'(d1_lvl), 32'((k < 8) ? k : 8));
      chk("bp_ovf", 32'(d1_ovf), 32'(k >= 9));
      chk("bp_head", 32'(d1_dat), 32'h100);
    end
    nd  = 1'b0;
    rdy = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("drain_lvl", 32'(d1_lvl), 32'(8 - j));
      chk("drain_vld", 32'(d1_vld), 32'(j < 8));
      if (j < 8)
        chk("drain_dat", 32'(d1_dat), 32'(32'h100 + j));
    end
    chk("drain_ovf_sticky", 32'(d1_ovf), 1);

    // Full buffer with simultaneous read and write: no drop, level pinned at 8
    do_reset();
    for (int k = 0; k < 8; k++) begin
      din = DW'(32'h200 + k);
      nd  = 1'b1;
      step();
    end
    chk("full_lvl", 32'(d1_lvl), 8);
    rdy = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      din = DW'(32'h207 + m);
      step();
      chk("rw_lvl", 32'(d1_lvl), 8);
      chk("rw_ovf", 32'(d1_ovf), 0);
      chk("rw_dat", 32'(d1_dat), 32'(32'h200 + m));
    end
    nd = 1'b0;
    for (int m = 9; m <= 15; m++) begin
      step();
      chk("rw_drain_dat", 32'(d1_dat), 32'(32'h200 + m));
    end
    step();
    chk("rw_empty_vld", 32'(d1_vld), 0);
    chk("rw_empty_lvl", 32'(d1_lvl), 0);

    // Gapped input at DECIM=3: kept indices 0,3,6,9
    do_reset();
    rdy = 1'b1;
    for (int n = 0; n < 12; n++) begin
      din = DW'(32'h300 + n);
      nd  = 1'b1;
      step();
      chk("gap_vld", 32'(d3_vld), 32'((n % 3) == 0));
      chk("gap_dat", 32'(d3_dat), 32'(32'h300 + n - (n % 3)));
      nd = 1'b0;
      step();
      chk("gap_idle_vld", 32'(d3_vld), 0);
    end

    // Overflow clear: set wins over clear on a drop edge, clear alone then works
    do_reset();
    for (int k = 0; k < 9; k++) begin
      din = DW'(32'h400 + k);
      nd  = 1'b1;
      step();
    end
    chk("ovf_set", 32'(d1_ovf), 1);
    din = DW'(32'h409);
    clr = 1'b1;
    step();
    chk("ovf_set_wins", 32'(d1_ovf), 1);
    chk("ovf_lvl", 32'(d1_lvl), 8);
    nd = 1'b0;
    step();
    chk("ovf_cleared", 32'(d1_ovf), 0);
    clr = 1'b0;
    chk("ovf_head_kept", 32'(d1_dat), 32'h400);

    // Asynchronous reset mid-operation, then phase restarts at zero
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      din = DW'(32'h500 + k);
      nd  = 1'b1;
      step();
    end
    chk("pre_rst_lvl", 32'(d1_lvl), 5);
    chk("pre_rst_vld", 32'(d1_vld), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_d1_lvl", 32'(d1_lvl), 0);
    chk("arst_d1_vld", 32'(d1_vld), 0);
    chk("arst_d1_dat", 32'(d1_dat), 0);
    chk("arst_d4_dat", 32'(d4_dat), 0);
    din = DW'(32'h555);
    nd  = 1'b1;
    rdy = 1'b1;
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_d4_vld", 32'(d4_vld), 1);
    chk("post_rst_d4_dat", 32'(d4_dat), 32'h555);
    chk("post_rst_d1_lvl", 32'(d1_lvl), 1);
    nd = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
